// File: rtl/load_store_unit_if.sv
// Bus bundle between the pipeline, the load/store unit and data_mem.
// The LSU takes the slave view; the pipeline/data_mem side takes the master view.
interface load_store_unit_if;
    // request from execute/mem stage
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // response back to the pipeline (no backpressure)
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    // data_mem read/write ports
    logic        dmem_re;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               dmem_re, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               dmem_re, dmem_raddr, dmem_we, dmem_waddr, dmem_wdata, dmem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit sitting in front of data_mem.
// Stores are issued in the accept cycle and answered one cycle later; loads
// issue the read, wait LOAD_LAT cycles, then extract/extend the selected lane.
// Illegal, misaligned and out-of-range requests never reach data_mem.
module load_store_unit #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned SIZE_BYTES = 4096,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam int          CW    = $clog2(LOAD_LAT + 1);
    // one past the last backed byte, kept 33 bits wide so the top of the
    // address space cannot wrap into range
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES);

    localparam logic [1:0] E_OK    = 2'b00;
    localparam logic [1:0] E_ALIGN = 2'b01;
    localparam logic [1:0] E_RANGE = 2'b10;
    localparam logic [1:0] E_ILL   = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ld_f3_q, ld_f3_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]    resp_err_q, resp_err_d;

    logic [2:0]  f3;
    logic [31:0] addr;
    logic        ready;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  size_m1;
    logic [32:0] last_byte;
    logic [1:0]  dec_err;
    logic        do_store;
    logic        do_load;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign f3     = bus.req_funct3;
    assign addr   = bus.req_addr;
    // requests are only taken when no load is outstanding
    assign ready  = ((state_q == S_IDLE) || (state_q == S_RESP)) && !rst;
    assign accept = bus.req_valid && ready;

    // Request decode: legality, alignment and range, with error priority
    always_comb begin
        illegal = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.req_we;   // BU/HU exist only for loads
            default:                illegal = 1'b1;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (f3[1:0])
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
        last_byte    = {1'b0, addr} + {31'b0, size_m1};
        out_of_range = ({1'b0, addr} < {1'b0, BASE_ADDR}) || (last_byte >= LIMIT);
        if (illegal)
            dec_err = E_ILL;
        else if (misaligned)
            dec_err = E_ALIGN;
        else if (out_of_range)
            dec_err = E_RANGE;
        else
            dec_err = E_OK;
    end

    assign do_store = accept && (dec_err == E_OK) &&  bus.req_we;
    assign do_load  = accept && (dec_err == E_OK) && !bus.req_we;

    // Store lane steering: strobes select bytes, data replicated to every lane
    always_comb begin
        case (f3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr[1:0];
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'hF;
                st_data = bus.req_wdata;
            end
        endcase
    end

    assign bus.req_ready  = ready;
    assign bus.dmem_we    = do_store;
    assign bus.dmem_waddr = {addr[31:2], 2'b00};
    assign bus.dmem_wstrb = do_store ? st_strb : 4'h0;
    assign bus.dmem_wdata = do_store ? st_data : 32'h0;
    assign bus.dmem_re    = do_load;
    assign bus.dmem_raddr = {addr[31:2], 2'b00};

    // Load lane extraction from the registered size/offset of the pending load
    always_comb begin
        ld_shift = bus.dmem_rdata >> {ld_off_q, 3'b000};
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    // Next-state: accept in IDLE/RESP, count down read latency in LD_WAIT
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept) begin
                    if ((dec_err != E_OK) || bus.req_we) begin
                        // stores and errors answer next cycle with no data
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = dec_err;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d  = S_LD_WAIT;
                        cnt_d    = CW'(LOAD_LAT);
                        ld_f3_d  = f3;
                        ld_off_d = addr[1:0];
                    end
                end
            end
            S_LD_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // last wait cycle: dmem_rdata holds the word read in the accept cycle
                if (cnt_q == CW'(1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = E_OK;
                    resp_rdata_d = ld_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; reset drops any in-flight load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ld_f3_q      <= 3'b000;
            ld_off_q     <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3), each with
// a simple data_mem model, checked against a byte-level reference memory.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          SIZE  = 4096;
    localparam int          LAT_A = 1;
    localparam int          LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if a_if ();
    load_store_unit_if b_if ();

    load_store_unit #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .LOAD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if));
    load_store_unit #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .LOAD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if));

    // shared request drive, routed to one instance by sel
    logic        sel = 1'b0;
    logic        vld = 1'b0;
    logic        we  = 1'b0;
    logic [2:0]  f3  = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    assign a_if.req_valid  = vld & ~sel;
    assign a_if.req_we     = we;
    assign a_if.req_funct3 = f3;
    assign a_if.req_addr   = addr;
    assign a_if.req_wdata  = wdata;
    assign b_if.req_valid  = vld & sel;
    assign b_if.req_we     = we;
    assign b_if.req_funct3 = f3;
    assign b_if.req_addr   = addr;
    assign b_if.req_wdata  = wdata;

    // data_mem models: word arrays, reads return after LAT cycles, junk otherwise
    logic        init = 1'b1;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] rd_a;
    logic [31:0] pipe_b [3];

    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 1024; k++) mem_a[k] <= 32'h0;
        end else if (a_if.dmem_we) begin
            for (int i = 0; i < 4; i++)
                if (a_if.dmem_wstrb[i]) mem_a[a_if.dmem_waddr[11:2]][8*i +: 8] <= a_if.dmem_wdata[8*i +: 8];
        end
        rd_a <= a_if.dmem_re ? mem_a[a_if.dmem_raddr[11:2]] : $urandom;
    end
    assign a_if.dmem_rdata = rd_a;

    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 1024; k++) mem_b[k] <= 32'h0;
        end else if (b_if.dmem_we) begin
            for (int i = 0; i < 4; i++)
                if (b_if.dmem_wstrb[i]) mem_b[b_if.dmem_waddr[11:2]][8*i +: 8] <= b_if.dmem_wdata[8*i +: 8];
        end
        pipe_b[0] <= b_if.dmem_re ? mem_b[b_if.dmem_raddr[11:2]] : $urandom;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_if.dmem_rdata = pipe_b[2];

    // observed outputs of the selected instance
    logic        o_ready, o_rv, o_re, o_we;
    logic [31:0] o_rdata, o_wdata;
    logic [1:0]  o_err;
    logic [3:0]  o_wstrb;
    always_comb begin
        if (sel) begin
            o_ready = b_if.req_ready; o_rv = b_if.resp_valid; o_rdata = b_if.resp_rdata;
            o_err = b_if.resp_err; o_re = b_if.dmem_re; o_we = b_if.dmem_we;
            o_wstrb = b_if.dmem_wstrb; o_wdata = b_if.dmem_wdata;
        end else begin
            o_ready = a_if.req_ready; o_rv = a_if.resp_valid; o_rdata = a_if.resp_rdata;
            o_err = a_if.resp_err; o_re = a_if.dmem_re; o_we = a_if.dmem_we;
            o_wstrb = a_if.dmem_wstrb; o_wdata = a_if.dmem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    // reference: byte-addressed memories and the architectural load/store rules
    logic [7:0] ref_a [SIZE];
    logic [7:0] ref_b [SIZE];

    function automatic void model(input bit s, input logic w, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [1:0] er, output logic [31:0] rd);
        int n;
        int idx;
        logic [31:0] v;
        n  = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        rd = 32'h0;
        if (f == 3'd3 || f >= 3'd6 || (w && f >= 3'd4)) er = 2'b11;
        else if ((a % n) != 0) er = 2'b01;
        else if (64'(a) < 64'(BASE) || 64'(a) + 64'(n) > 64'(BASE) + 64'(SIZE)) er = 2'b10;
        else begin
            er  = 2'b00;
            idx = int'(a - BASE);
            if (w) begin
                for (int i = 0; i < n; i++)
                    if (s) ref_b[idx+i] = d[8*i +: 8]; else ref_a[idx+i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++)
                    v[8*i +: 8] = s ? ref_b[idx+i] : ref_a[idx+i];
                if (f < 3'd4 && n < 4 && v[8*n-1])
                    for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
                rd = v;
            end
        end
    endfunction

    typedef struct {
        int          lat;
        int          busy;
        logic [31:0] rd;
        logic [1:0]  er;
        logic        re;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          late_strobe;
        bit          to;
    } obs_t;

    // drive one request, record accept-cycle strobes and the response
    task automatic issue(input bit s, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, output obs_t o);
        int n;
        o = '{default: 0};
        @(posedge clk); #1;
        sel = s; vld = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        if (!o_ready) o.to = 1;
        o.re = o_re; o.we = o_we; o.wstrb = o_wstrb; o.wdata = o_wdata;
        @(posedge clk); #1;
        vld = 1'b0; addr = $urandom; wdata = $urandom;
        do begin
            @(negedge clk);
            o.lat++;
            if (o_re || o_we) o.late_strobe = 1;
            if (!o_ready) o.busy++;
        end while (!o_rv && o.lat < 20);
        if (!o_rv) o.to = 1;
        o.rd = o_rdata; o.er = o_err;
    endtask

    task automatic test_reset();
        vld = 1'b1; sel = 1'b0; we = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'h1;
        @(negedge clk);
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", o_ready); end
        total++; if (o_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", o_we); end
        total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", o_rv); end
        total++; if (o_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", o_rdata); end
        total++; if (o_err !== 2'b00) begin bad++; $display("FAIL rst_err got=%b want=0", o_err); end
        we = 1'b0;
        @(negedge clk);
        init = 1'b0;
        total++; if (o_re !== 1'b0) begin bad++; $display("FAIL rst_re got=%b want=0", o_re); end
        vld = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", o_ready); end
    endtask

    task automatic test_store_load();
        obs_t o; logic [1:0] er; logic [31:0] rd;
        model(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, er, rd);
        issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
        total++; if (o.we !== 1'b1 || o.wstrb !== 4'hF) begin bad++; $display("FAIL sw_strobe we=%b wstrb=%h want 1/F", o.we, o.wstrb); end
        total++; if (o.wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef", o.wdata); end
        total++; if (o.lat !== 1 || o.er !== er || o.rd !== 32'h0) begin bad++; $display("FAIL sw_resp lat=%0d err=%b rd=%h want 1/%b/0", o.lat, o.er, o.rd, er); end
        model(0, 1'b0, 3'b010, 32'h10, 32'h0, er, rd);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, o);
        total++; if (o.re !== 1'b1 || o.we !== 1'b0) begin bad++; $display("FAIL lw_strobe re=%b we=%b want 1/0", o.re, o.we); end
        total++; if (o.lat !== 2) begin bad++; $display("FAIL lw_lat got=%0d want=2", o.lat); end
        total++; if (o.rd !== 32'hDEADBEEF || o.er !== 2'b00) begin bad++; $display("FAIL lw_data got=%h err=%b want=deadbeef/00", o.rd, o.er); end
    endtask

    task automatic test_byte();
        obs_t o; logic [1:0] er; logic [31:0] rd;
        model(0, 1'b1, 3'b000, 32'h13, 32'h000000A5, er, rd);
        issue(0, 1'b1, 3'b000, 32'h13, 32'h000000A5, o);
        total++; if (o.wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b want=1000", o.wstrb); end
        total++; if (o.wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", o.wdata); end
        model(0, 1'b0, 3'b000, 32'h13, 32'h0, er, rd);
        issue(0, 1'b0, 3'b000, 32'h13, 32'h0, o);
        total++; if (o.rd !== 32'hFFFFFFA5 || o.rd !== rd) begin bad++; $display("FAIL lb got=%h want=ffffffa5", o.rd); end
        model(0, 1'b0, 3'b100, 32'h13, 32'h0, er, rd);
        issue(0, 1'b0, 3'b100, 32'h13, 32'h0, o);
        total++; if (o.rd !== 32'h000000A5 || o.rd !== rd) begin bad++; $display("FAIL lbu got=%h want=000000a5", o.rd); end
    endtask

    task automatic test_errors();
        logic        t_we [8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  t_f3 [8]  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b010, 3'b010, 3'b001};
        logic [31:0] t_ad [8]  = '{32'h11, 32'h1000, 32'h20, 32'h20, 32'h21, 32'hFFC, 32'hFFFFFFFC, 32'h1001};
        logic [1:0]  t_er [8]  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01};
        obs_t o; logic [1:0] er; logic [31:0] rd;
        for (int i = 0; i < 8; i++) begin
            model(0, t_we[i], t_f3[i], t_ad[i], 32'h55AA55AA, er, rd);
            issue(0, t_we[i], t_f3[i], t_ad[i], 32'h55AA55AA, o);
            total++;
            if (o.er !== t_er[i] || o.rd !== rd) begin
                bad++; $display("FAIL err_case%0d err=%b rd=%h want %b/%h", i, o.er, o.rd, t_er[i], rd);
            end
            if (t_er[i] != 2'b00) begin
                total++;
                if (o.re !== 1'b0 || o.we !== 1'b0 || o.lat !== 1) begin
                    bad++; $display("FAIL err_nomem%0d re=%b we=%b lat=%0d want 0/0/1", i, o.re, o.we, o.lat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; logic [1:0] er; logic [31:0] rd;
        @(posedge clk); #1;
        sel = 1'b0; vld = 1'b1; we = 1'b1; f3 = 3'b001; addr = 32'h2; wdata = 32'h12345678;
        model(0, 1'b1, 3'b001, 32'h2, 32'h12345678, er, rd);
        @(negedge clk);
        total++; if (o_ready !== 1'b1 || o_we !== 1'b1 || o_wstrb !== 4'b1100) begin bad++; $display("FAIL b2b_sh rdy=%b we=%b wstrb=%b want 1/1/1100", o_ready, o_we, o_wstrb); end
        @(posedge clk); #1;
        f3 = 3'b010; addr = 32'h4; wdata = 32'hCAFEF00D;
        model(0, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, er, rd);
        @(negedge clk);
        total++; if (o_ready !== 1'b1 || o_rv !== 1'b1 || o_we !== 1'b1 || o_wstrb !== 4'hF) begin bad++; $display("FAIL b2b_sw rdy=%b rv=%b we=%b wstrb=%h want 1/1/1/f", o_ready, o_rv, o_we, o_wstrb); end
        @(posedge clk); #1; vld = 1'b0;
        @(negedge clk);
        total++; if (o_rv !== 1'b1 || o_ready !== 1'b1 || o_err !== 2'b00) begin bad++; $display("FAIL b2b_resp2 rv=%b rdy=%b err=%b want 1/1/00", o_rv, o_ready, o_err); end
        @(negedge clk);
        total++; if (o_rv !== 1'b0) begin bad++; $display("FAIL b2b_pulse rv=%b want=0", o_rv); end
        model(0, 1'b0, 3'b010, 32'h0, 32'h0, er, rd);
        issue(0, 1'b0, 3'b010, 32'h0, 32'h0, o);
        total++; if (o.rd !== rd) begin bad++; $display("FAIL b2b_lw0 got=%h want=%h", o.rd, rd); end
        model(0, 1'b0, 3'b010, 32'h4, 32'h0, er, rd);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, o);
        total++; if (o.rd !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_lw4 got=%h want=cafef00d", o.rd); end
    endtask

    task automatic test_reset_mid_load();
        obs_t o; logic [1:0] er; logic [31:0] rd;
        int seen;
        @(posedge clk); #1;
        sel = 1'b0; vld = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10;
        @(negedge clk);
        total++; if (o_re !== 1'b1) begin bad++; $display("FAIL rml_issue re=%b want=1", o_re); end
        @(posedge clk); #1; vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (o_rv !== 1'b0 || o_rdata !== 32'h0 || o_err !== 2'b00 || o_ready !== 1'b0) begin
            bad++; $display("FAIL rml_outs rv=%b rd=%h err=%b rdy=%b want all 0", o_rv, o_rdata, o_err, o_ready); end
        @(posedge clk); #1; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (o_rv) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rml_noresp pulses=%0d want=0", seen); end
        model(0, 1'b1, 3'b010, 32'h0, 32'h80011234, er, rd);
        issue(0, 1'b1, 3'b010, 32'h0, 32'h80011234, o);
        model(0, 1'b0, 3'b101, 32'h2, 32'h0, er, rd);
        issue(0, 1'b0, 3'b101, 32'h2, 32'h0, o);
        total++; if (o.rd !== 32'h00008001 || o.er !== 2'b00) begin bad++; $display("FAIL rml_lhu got=%h err=%b want=00008001/00", o.rd, o.er); end
    endtask

    task automatic test_lat3();
        obs_t o; logic [1:0] er; logic [31:0] rd;
        model(1, 1'b1, 3'b010, 32'h40, 32'h13572468, er, rd);
        issue(1, 1'b1, 3'b010, 32'h40, 32'h13572468, o);
        total++; if (o.lat !== 1 || o.er !== 2'b00) begin bad++; $display("FAIL l3_sw lat=%0d err=%b want 1/00", o.lat, o.er); end
        model(1, 1'b0, 3'b010, 32'h40, 32'h0, er, rd);
        issue(1, 1'b0, 3'b010, 32'h40, 32'h0, o);
        total++; if (o.busy !== 3) begin bad++; $display("FAIL l3_busy got=%0d want=3", o.busy); end
        total++; if (o.lat !== 4) begin bad++; $display("FAIL l3_lat got=%0d want=4", o.lat); end
        total++; if (o.rd !== 32'h13572468) begin bad++; $display("FAIL l3_data got=%h want=13572468", o.rd); end
    endtask

    task automatic test_random(input bit s, input int count);
        obs_t o; logic [1:0] er; logic [31:0] rd;
        logic w; logic [2:0] f; logic [31:0] a, d;
        int mode, elat;
        for (int i = 0; i < count; i++) begin
            w    = 1'($urandom_range(0, 1));
            f    = 3'($urandom_range(0, 7));
            d    = $urandom;
            mode = int'($urandom_range(0, 9));
            if (mode == 0)      a = 32'hFF8 + 32'($urandom_range(0, 7));
            else if (mode == 1) a = $urandom | 32'h1000;
            else                a = 32'($urandom_range(0, 127));
            model(s, w, f, a, d, er, rd);
            issue(s, w, f, a, d, o);
            elat = (er != 2'b00 || w) ? 1 : 1 + (s ? LAT_B : LAT_A);
            total++;
            if (o.to || o.er !== er || o.rd !== rd || o.lat !== elat) begin
                bad++; $display("FAIL rand%0d_%0d we=%b f3=%b a=%h err=%b rd=%h lat=%0d want %b/%h/%0d", s, i, w, f, a, o.er, o.rd, o.lat, er, rd, elat);
            end
            total++;
            if (o.re !== (er == 2'b00 && !w) || o.we !== (er == 2'b00 && w) || o.late_strobe) begin
                bad++; $display("FAIL rand_strobe%0d_%0d re=%b we=%b late=%0d err=%b", s, i, o.re, o.we, o.late_strobe, er);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < SIZE; k++) begin ref_a[k] = 8'h0; ref_b[k] = 8'h0; end
        test_reset();
        test_store_load();
        test_byte();
        test_errors();
        test_back_to_back();
        test_reset_mid_load();
        test_lat3();
        test_random(0, 150);
        test_random(1, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
